stream_to_array: RTL and testbench
==================================

Name: stream_to_array

Overview:
Writer-side kernel for the two-port array RAM.
- Accepts a valid/ready input stream.
- Stores `n` consecutive elements into the RAM at addresses 0..n-1.
- Reports the modular sum of the stored elements.
- Uses the same memory-port bundle as the array-reading kernels, so it plugs onto `bram_2p` and is the producer that fills the array a summing kernel later consumes.
- Start/finish control matches the other kernels.

Parameters:
- DATA_W, 32, element and checksum width
- ADDR_W, 10, array address width; also the width of `n`

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a fill; sampled only in IDLE
- finish  out  1  one-cycle pulse: fill complete, all writes committed
- n  in  ADDR_W  element count, latched on accepted start
- in_valid  in  1  stream element valid
- in_ready  out  1  stream element accepted when in_valid && in_ready
- in_data  in  DATA_W  stream element
- res  out  DATA_W  sum of written elements mod 2^DATA_W; valid while finish=1, held until next start
- arr_clk  out  1  RAM clock, driven directly from clk
- arr_read_en  out  1  tied 0
- arr_read_addr  out  ADDR_W  tied 0
- arr_read_val  in  DATA_W  unused
- arr_write_en  out  1  RAM write strobe
- arr_write_addr  out  ADDR_W  RAM write address
- arr_write_val  out  DATA_W  RAM write data

Behaviour:
- Clock and reset
  - One clock, `clk`.
  - `rst_n` is asynchronous and active-low. Assertion clears all state immediately.
- Reset values
  - State = IDLE.
  - `finish`, `in_ready`, `arr_write_en` = 0.
  - `arr_write_addr`, `arr_write_val`, `res` = 0.
  - Internal index and accumulator = 0.
- States: IDLE, WRITE, DONE.
- IDLE
  - `in_ready` = 0.
  - On `start`: latch `n`, clear index and accumulator.
  - If `n` != 0, go to WRITE; if `n` == 0, go to DONE.
- WRITE
  - `in_ready` = 1 (combinational from state).
  - On handshake in cycle t:
    - `arr_write_en` = 1, `arr_write_addr` = index, `arr_write_val` = `in_data`, all registered and visible in cycle t+1 for exactly one cycle.
    - Accumulator += `in_data`, wrapping mod 2^DATA_W.
    - Index increments.
  - The handshake with index == n_lat-1 moves the state to DONE.
  - No handshake: `arr_write_en` = 0 next cycle; state and index unchanged. Bubbles are unlimited.
- DONE
  - Lasts exactly one cycle; it coincides with the last write strobe.
  - Next cycle: state = IDLE, `finish` = 1 for one cycle, `res` = accumulator.
- Latency
  - `finish` is asserted 2 cycles after the last handshake.
  - With n == 0, `finish` is asserted 2 cycles after start.
  - The RAM has captured every write before `finish` rises.
- `start` outside IDLE is ignored.
- `start` in the same cycle `finish` is high is accepted; that cycle is IDLE.
- Stream data presented outside WRITE is not consumed.
- `res` holds its value until the next accepted start, then is reloaded at the next `finish`.
- Addresses never exceed n_lat-1; no wrap occurs. Maximum fill is 2^ADDR_W-1 elements.
- Reset mid-fill: an in-flight write strobe is dropped, `finish` does not fire, and RAM contents already written are undefined to the kernel.
- `arr_read_val` must not influence any output.

Decomposition:
- Shared package (with the other array kernels): state enum {IDLE, WRITE, DONE}; default DATA_W/ADDR_W constants.
- Single module; no sub-module is natural.

Test Plan:
- n=4, in_valid continuously high with 5,6,7,8:
  - writes (0,5),(1,6),(2,7),(3,8) on consecutive cycles.
  - `finish` pulses 2 cycles after the 4th handshake; `res` = 26.
  - A `sum_of_array` run on the same RAM returns 26.
- n=3, in_valid toggling 1,0,0,1,0,1 with 10,20,30:
  - exactly 3 write strobes at addrs 0,1,2; no strobe in bubble cycles.
  - `res` = 60.
- n=0:
  - `finish` 2 cycles after start, `res` = 0, no write strobe, `in_ready` never high.
- Wrap: n=2, data 0xFFFFFFFF, 0x00000002 -> `res` = 0x00000001.
- `start` pulsed mid-fill (n=5) -> ignored: exactly 5 writes, one `finish`.
- `rst_n` low after 2 of 4 writes:
  - outputs zero immediately; no further strobes; no `finish`.
  - A fresh start with n=1, data 9 gives a write at addr 0 and `res` = 9.

Source files
------------

// File: rtl/stream_to_array_pkg.sv
// Shared definitions for the array kernels: FSM state encoding and default widths.
package stream_to_array_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/stream_to_array.sv
// Writer kernel: takes n elements from a valid/ready stream, writes them to
// array addresses 0..n-1 and reports their modular sum when the fill is done.
module stream_to_array
  import stream_to_array_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              finish,
  input  logic [ADDR_W-1:0] n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] res,
  output logic              arr_clk,
  output logic              arr_read_en,
  output logic [ADDR_W-1:0] arr_read_addr,
  input  logic [DATA_W-1:0] arr_read_val,
  output logic              arr_write_en,
  output logic [ADDR_W-1:0] arr_write_addr,
  output logic [DATA_W-1:0] arr_write_val
);

  state_t              state_reg;
  state_t              state_next;
  logic [ADDR_W-1:0]   n_lat_reg;
  logic [ADDR_W-1:0]   index_reg;
  logic [DATA_W-1:0]   acc_reg;
  logic                write_en_reg;
  logic [ADDR_W-1:0]   write_addr_reg;
  logic [DATA_W-1:0]   write_val_reg;
  logic                finish_reg;
  logic [DATA_W-1:0]   res_reg;

  logic                start_ok;
  logic                handshake;
  logic                last_elem;

  // The read port is never used by a writer; keep it quiet but unconnected to any output.
  logic                unused_read;
  assign unused_read = ^arr_read_val;

  assign arr_clk        = clk;
  assign arr_read_en    = 1'b0;
  assign arr_read_addr  = '0;

  // Stream acceptance is purely a function of state, so in_ready has no path from in_valid.
  assign in_ready  = (state_reg == WRITE);
  assign handshake = in_ready && in_valid;
  assign start_ok  = (state_reg == IDLE) && start;
  assign last_elem = (index_reg == (n_lat_reg - ADDR_W'(1)));

  assign finish         = finish_reg;
  assign res            = res_reg;
  assign arr_write_en   = write_en_reg;
  assign arr_write_addr = write_addr_reg;
  assign arr_write_val  = write_val_reg;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a zero-length fill skips straight to DONE so finish timing stays uniform.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = (n != '0) ? WRITE : DONE;
        end
      end
      WRITE: begin
        if (handshake && last_elem) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Fill bookkeeping: latch the count on start, then advance index and sum per accepted element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_lat_reg <= '0;
      index_reg <= '0;
      acc_reg   <= '0;
    end else if (start_ok) begin
      n_lat_reg <= n;
      index_reg <= '0;
      acc_reg   <= '0;
    end else if (handshake) begin
      index_reg <= index_reg + ADDR_W'(1);
      acc_reg   <= acc_reg + in_data;
    end
  end

  // Registered RAM write port: one strobe, the cycle after each accepted element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_en_reg   <= 1'b0;
      write_addr_reg <= '0;
      write_val_reg  <= '0;
    end else begin
      write_en_reg <= handshake;
      if (handshake) begin
        write_addr_reg <= index_reg;
        write_val_reg  <= in_data;
      end
    end
  end

  // Completion: DONE overlaps the last strobe, so finish lands after the RAM has it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      finish_reg <= 1'b0;
      res_reg    <= '0;
    end else begin
      finish_reg <= (state_reg == DONE);
      if (state_reg == DONE) begin
        res_reg <= acc_reg;
      end
    end
  end

endmodule

// File: tb/tb_stream_to_array.sv
// Scoreboard bench for stream_to_array: stimulus queues expected writes and
// completions, a monitor compares them as the DUT presents strobes / finish.
module tb_stream_to_array;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              finish;
  logic [ADDR_W-1:0] n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] res;
  logic              arr_clk;
  logic              arr_read_en;
  logic [ADDR_W-1:0] arr_read_addr;
  logic [DATA_W-1:0] arr_read_val;
  logic              arr_write_en;
  logic [ADDR_W-1:0] arr_write_addr;
  logic [DATA_W-1:0] arr_write_val;

  stream_to_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .finish         (finish),
    .n              (n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .res            (res),
    .arr_clk        (arr_clk),
    .arr_read_en    (arr_read_en),
    .arr_read_addr  (arr_read_addr),
    .arr_read_val   (arr_read_val),
    .arr_write_en   (arr_write_en),
    .arr_write_addr (arr_write_addr),
    .arr_write_val  (arr_write_val)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;
  } wr_t;

  typedef struct {
    logic [DATA_W-1:0] res;
    int                cyc;
  } fin_t;

  wr_t  exp_wr_q[$];
  fin_t exp_fin_q[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit no_ready_mode = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT shows a write strobe or finish.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (arr_write_en) begin
          if (exp_wr_q.size() == 0) begin
            check("unexpected_write", 64'(arr_write_addr), 64'hFFFF);
          end else begin
            wr_t w;
            w = exp_wr_q.pop_front();
            check("write_addr", 64'(arr_write_addr), 64'(w.addr));
            check("write_val", 64'(arr_write_val), 64'(w.val));
            $display("write addr=%0d val=0x%0h cycle=%0d", arr_write_addr, arr_write_val, cyc);
          end
        end
        if (finish) begin
          if (exp_fin_q.size() == 0) begin
            check("unexpected_finish", 64'(res), 64'hDEAD_0000_0000);
          end else begin
            fin_t f;
            f = exp_fin_q.pop_front();
            check("res", 64'(res), 64'(f.res));
            check("finish_cycle", 64'(cyc), 64'(f.cyc));
            $display("finish res=0x%0h cycle=%0d", res, cyc);
          end
        end
        if (no_ready_mode) begin
          check("in_ready_n0", 64'(in_ready), 64'd0);
        end
      end
    end
  end

  task automatic do_start(input logic [ADDR_W-1:0] cnt, output int scyc);
    @(posedge clk); #1;
    start = 1'b1;
    n     = cnt;
    @(negedge clk);
    scyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one element and hold it until accepted; returns the handshake cycle.
  task automatic send(input logic [DATA_W-1:0] d, output int hcyc);
    bit done;
    done = 1'b0;
    hcyc = -1;
    if (!($time == 0)) begin end
    in_valid = 1'b1;
    in_data  = d;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
        hcyc = cyc;
      end
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 32'hBAD0_BAD0;
  endtask

  task automatic bubble(input int k);
    in_valid = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (exp_fin_q.size() == 0 && exp_wr_q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      check(name, 64'(exp_fin_q.size() + exp_wr_q.size()), 64'd0);
      exp_fin_q.delete();
      exp_wr_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
    wr_t w;
    w.addr = a;
    w.val  = v;
    exp_wr_q.push_back(w);
  endtask

  task automatic push_fin(input logic [DATA_W-1:0] r, input int c);
    fin_t f;
    f.res = r;
    f.cyc = c;
    exp_fin_q.push_back(f);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_finish"}, 64'(finish), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_write_en"}, 64'(arr_write_en), 64'd0);
    check({tag, "_write_addr"}, 64'(arr_write_addr), 64'd0);
    check({tag, "_write_val"}, 64'(arr_write_val), 64'd0);
    check({tag, "_res"}, 64'(res), 64'd0);
    check({tag, "_read_en"}, 64'(arr_read_en), 64'd0);
  endtask

  initial begin
    int sc;
    int hc;
    rst_n        = 1'b0;
    start        = 1'b0;
    n            = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    arr_read_val = 32'hA5A5_A5A5;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    bubble(2);

    // n=4, continuous stream 5,6,7,8 -> sum 26
    push_wr(0, 5); push_wr(1, 6); push_wr(2, 7); push_wr(3, 8);
    do_start(4, sc);
    send(5, hc); send(6, hc); send(7, hc); send(8, hc);
    push_fin(26, hc + 2);
    drain("t1_timeout");

    // n=3 with bubbles: valid pattern 1,0,0,1,0,1 -> sum 60
    push_wr(0, 10); push_wr(1, 20); push_wr(2, 30);
    do_start(3, sc);
    send(10, hc); bubble(2); send(20, hc); bubble(1); send(30, hc);
    push_fin(60, hc + 2);
    drain("t2_timeout");

    // n=0: finish two cycles after start, no strobes, in_ready stays low
    no_ready_mode = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h1234_5678;
    do_start(0, sc);
    push_fin(0, sc + 2);
    drain("t3_timeout");
    no_ready_mode = 1'b0;
    in_valid = 1'b0;

    // wrap: 0xFFFFFFFF + 2 = 1
    push_wr(0, 32'hFFFF_FFFF); push_wr(1, 32'h0000_0002);
    do_start(2, sc);
    send(32'hFFFF_FFFF, hc); send(32'h0000_0002, hc);
    push_fin(32'h0000_0001, hc + 2);
    drain("t4_timeout");

    // start pulsed mid-fill must be ignored: still 5 writes, one finish, sum 15
    for (int i = 0; i < 5; i++) push_wr(ADDR_W'(i), 32'(i + 1));
    do_start(5, sc);
    send(1, hc); send(2, hc);
    start = 1'b1; n = 2; bubble(1); start = 1'b0;
    send(3, hc); send(4, hc); send(5, hc);
    push_fin(15, hc + 2);
    drain("t5_timeout");

    // reset after 2 of 4 writes: outputs clear immediately, nothing follows
    push_wr(0, 1); push_wr(1, 2);
    do_start(4, sc);
    send(1, hc); send(2, hc);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midreset");
    in_valid = 1'b1;
    in_data  = 32'h0000_0003;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bubble(6);
    check("midreset_leftover_writes", 64'(exp_wr_q.size()), 64'd0);

    // fresh fill after reset: n=1, data 9
    push_wr(0, 9);
    do_start(1, sc);
    send(9, hc);
    push_fin(9, hc + 2);
    drain("t6_timeout");
    bubble(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
